// File: rtl/isa_mon_pkg.sv
// Shared types, message constants and the nibble-to-ASCII helper for the
// ISA result monitor.
package isa_mon_pkg;

  // Top-level monitor phases: counting, sending the verdict text, parked.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_REPORT = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

  // What kind of verdict message the serializer should emit.
  typedef enum logic [1:0] {
    KIND_PASS    = 2'd0,
    KIND_FAIL    = 2'd1,
    KIND_TIMEOUT = 2'd2
  } verdict_kind_e;

  // ASCII characters used in the verdict text.
  localparam logic [7:0] ASCII_P  = 8'h50;
  localparam logic [7:0] ASCII_F  = 8'h46;
  localparam logic [7:0] ASCII_T  = 8'h54;
  localparam logic [7:0] ASCII_NL = 8'h0A;

  // Message lengths in bytes: letter + newline, or letter + 8 hex digits + newline.
  localparam logic [3:0] MSG_LEN_SHORT = 4'd2;
  localparam logic [3:0] MSG_LEN_FAIL  = 4'd10;

  // Converts one nibble to its uppercase hexadecimal ASCII character.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    logic [7:0] wide;
    wide = {4'h0, nibble};
    if (nibble < 4'd10) begin
      return 8'h30 + wide;
    end
    return 8'h37 + wide;
  endfunction

endpackage

// File: rtl/verdict_serializer.sv
// Turns a latched verdict into a short ASCII message on a byte valid/ready
// stream. A start pulse loads the verdict and presents the first byte on the
// very next cycle; each handshake advances to the next byte, and the handshake
// on the final byte raises last_accepted for one cycle.
module verdict_serializer
  import isa_mon_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  verdict_kind_e kind,
  input  logic [31:0]   payload,
  input  logic          tx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  output logic          last_accepted
);

  verdict_kind_e kind_q, kind_d;
  logic [31:0]   payload_q, payload_d;
  logic [3:0]    index_q, index_d;
  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;

  logic [3:0]    msg_len;
  logic          accept;

  // Byte at position idx of the message for a given verdict kind and payload.
  // Position 0 is the verdict letter; fail messages carry the payload as
  // eight hex digits, most significant nibble first; the last byte is newline.
  function automatic logic [7:0] byte_at(input verdict_kind_e k,
                                         input logic [31:0] p,
                                         input logic [3:0] idx);
    logic [31:0] shifted;
    logic [4:0]  shamt;
    logic [7:0]  result;
    shamt   = {1'b0, (4'd8 - idx)} << 2;
    shifted = p >> shamt;
    result  = ASCII_NL;
    if (idx == 4'd0) begin
      case (k)
        KIND_PASS:    result = ASCII_P;
        KIND_FAIL:    result = ASCII_F;
        KIND_TIMEOUT: result = ASCII_T;
        default:      result = ASCII_T;
      endcase
    end else if ((k == KIND_FAIL) && (idx <= 4'd8)) begin
      result = hex_ascii(shifted[3:0]);
    end
    return result;
  endfunction

  assign msg_len       = (kind_q == KIND_FAIL) ? MSG_LEN_FAIL : MSG_LEN_SHORT;
  assign accept        = valid_q && tx_ready;
  assign last_accepted = accept && (index_q == (msg_len - 4'd1));

  assign tx_data  = data_q;
  assign tx_valid = valid_q;

  // Next-state logic: load on start, otherwise step through the message on
  // each handshake and drop valid after the final byte is taken.
  always_comb begin
    kind_d    = kind_q;
    payload_d = payload_q;
    index_d   = index_q;
    valid_d   = valid_q;
    data_d    = data_q;
    if (start) begin
      kind_d    = kind;
      payload_d = payload;
      index_d   = 4'd0;
      valid_d   = 1'b1;
      data_d    = byte_at(kind, payload, 4'd0);
    end else if (accept) begin
      if (last_accepted) begin
        valid_d = 1'b0;
        index_d = 4'd0;
      end else begin
        index_d = index_q + 4'd1;
        data_d  = byte_at(kind_q, payload_q, index_q + 4'd1);
      end
    end
  end

  // Message registers; an asserted reset abandons any partial message.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kind_q    <= KIND_PASS;
      payload_q <= 32'd0;
      index_q   <= 4'd0;
      valid_q   <= 1'b0;
      data_q    <= 8'd0;
    end else begin
      kind_q    <= kind_d;
      payload_q <= payload_d;
      index_q   <= index_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: rtl/isa_result_monitor.sv
// Watches CSR writes for the tohost verdict of a riscv-test, times out a run
// that never reports, counts cycles and retired instructions while the test
// runs, then sends a short ASCII verdict to a byte stream (e.g. a UART).
// TIMEOUT_CYCLES must be at least 1.
module isa_result_monitor
  import isa_mon_pkg::*;
#(
  parameter logic [11:0] TOHOST_ADDR    = 12'h51E,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        instr_retire,
  output logic        done,
  output logic        pass,
  output logic        timed_out,
  output logic [30:0] fail_id,
  output logic [31:0] cycle_count,
  output logic [31:0] instret,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [31:0] TIMEOUT_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_FINAL = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] COUNT_MAX     = 32'hFFFF_FFFF;

  state_e        state_q, state_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          timed_out_q, timed_out_d;
  logic [30:0]   fail_id_q, fail_id_d;
  logic [31:0]   cycle_count_q, cycle_count_d;
  logic [31:0]   instret_q, instret_d;

  logic          hit;
  logic          hit_is_pass;
  logic          at_timeout;
  logic          ser_start;
  verdict_kind_e ser_kind;
  logic [31:0]   ser_payload;
  logic          ser_last;

  // Only odd tohost writes carry a verdict; even ones are console traffic.
  assign hit         = csr_we && (csr_addr == TOHOST_ADDR) && csr_wdata[0];
  assign hit_is_pass = (csr_wdata[31:1] == 31'd0);
  assign at_timeout  = (cycle_count_q == TIMEOUT_LAST);

  assign done        = done_q;
  assign pass        = pass_q;
  assign timed_out   = timed_out_q;
  assign fail_id     = fail_id_q;
  assign cycle_count = cycle_count_q;
  assign instret     = instret_q;

  // FSM and status next-state: count while running, latch the first verdict
  // (a hit beats a simultaneous timeout), then wait for the message to drain.
  always_comb begin
    state_d       = state_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timed_out_d   = timed_out_q;
    fail_id_d     = fail_id_q;
    cycle_count_d = cycle_count_q;
    instret_d     = instret_q;
    ser_start     = 1'b0;
    ser_kind      = KIND_PASS;
    ser_payload   = 32'd0;
    case (state_q)
      ST_RUN: begin
        if (cycle_count_q != COUNT_MAX) begin
          cycle_count_d = cycle_count_q + 32'd1;
        end
        if (instr_retire && (instret_q != COUNT_MAX)) begin
          instret_d = instret_q + 32'd1;
        end
        if (hit) begin
          done_d      = 1'b1;
          pass_d      = hit_is_pass;
          timed_out_d = 1'b0;
          fail_id_d   = csr_wdata[31:1];
          state_d     = ST_REPORT;
          ser_start   = 1'b1;
          ser_kind    = hit_is_pass ? KIND_PASS : KIND_FAIL;
          ser_payload = {1'b0, csr_wdata[31:1]};
        end else if (at_timeout) begin
          cycle_count_d = TIMEOUT_FINAL;
          done_d        = 1'b1;
          pass_d        = 1'b0;
          timed_out_d   = 1'b1;
          fail_id_d     = 31'd0;
          state_d       = ST_REPORT;
          ser_start     = 1'b1;
          ser_kind      = KIND_TIMEOUT;
        end
      end
      ST_REPORT: begin
        if (ser_last) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State, status and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timed_out_q   <= 1'b0;
      fail_id_q     <= 31'd0;
      cycle_count_q <= 32'd0;
      instret_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timed_out_q   <= timed_out_d;
      fail_id_q     <= fail_id_d;
      cycle_count_q <= cycle_count_d;
      instret_q     <= instret_d;
    end
  end

  verdict_serializer u_serializer (
    .clk           (clk),
    .rst           (rst),
    .start         (ser_start),
    .kind          (ser_kind),
    .payload       (ser_payload),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .last_accepted (ser_last)
  );

endmodule

// File: tb/tb_isa_result_monitor.sv
// Self-checking bench for isa_result_monitor: directed scenarios plus a
// randomized loop, all judged against a verdict/message model kept here.
module tb_isa_result_monitor;

  localparam logic [11:0] TOHOST  = 12'h51E;
  localparam int          TIMEOUT = 2000;

  logic        clk;
  logic        rst;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        instr_retire;
  logic        done;
  logic        pass;
  logic        timed_out;
  logic [30:0] fail_id;
  logic [31:0] cycle_count;
  logic [31:0] instret;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed run cycles, retired count, latched verdict and
  // the exact byte string the verdict should produce.
  longint     m_cycles;
  longint     m_instret;
  bit         m_verdict;
  bit         m_pass;
  bit         m_timeout;
  logic [30:0] m_fail_id;
  logic [7:0] m_msg[$];
  string      hex_digits = "0123456789ABCDEF";

  isa_result_monitor #(
    .TOHOST_ADDR    (TOHOST),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .csr_we       (csr_we),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .instr_retire (instr_retire),
    .done         (done),
    .pass         (pass),
    .timed_out    (timed_out),
    .fail_id      (fail_id),
    .cycle_count  (cycle_count),
    .instret      (instret),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded loops.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Builds the expected message text for a verdict.
  task automatic model_build_message();
    logic [31:0] v;
    logic [3:0]  nib;
    m_msg.delete();
    if (m_timeout) begin
      m_msg.push_back(8'h54);
    end else if (m_pass) begin
      m_msg.push_back(8'h50);
    end else begin
      m_msg.push_back(8'h46);
      v = {1'b0, m_fail_id};
      for (int i = 7; i >= 0; i--) begin
        nib = v[4*i +: 4];
        m_msg.push_back(hex_digits[nib]);
      end
    end
    m_msg.push_back(8'h0A);
  endtask

  task automatic check_verdict(input string tag);
    check_output({tag, "_done"}, 32'(done), 32'd1);
    check_output({tag, "_pass"}, 32'(pass), 32'(m_pass));
    check_output({tag, "_timed_out"}, 32'(timed_out), 32'(m_timeout));
    check_output({tag, "_fail_id"}, 32'(fail_id), 32'(m_fail_id));
    check_output({tag, "_cycle_count"}, cycle_count, 32'(m_cycles));
    check_output({tag, "_instret"}, instret, 32'(m_instret));
    check_output({tag, "_tx_valid_first"}, 32'(tx_valid), 32'd1);
  endtask

  // Drives one cycle of CPU-side inputs and advances the model by one cycle.
  task automatic apply_stimulus(input bit we, input logic [11:0] addr,
                                input logic [31:0] wdata, input bit retire);
    csr_we       = we;
    csr_addr     = addr;
    csr_wdata    = wdata;
    instr_retire = retire;
    tick();
    csr_we       = 1'b0;
    instr_retire = 1'b0;
    if (!m_verdict) begin
      if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
      if (retire && (m_instret < 64'hFFFF_FFFF)) m_instret++;
      if (we && (addr == TOHOST) && wdata[0]) begin
        m_verdict = 1'b1;
        m_fail_id = wdata[31:1];
        m_pass    = (wdata[31:1] == 31'd0);
        m_timeout = 1'b0;
        model_build_message();
        check_verdict("hit");
      end else if (m_cycles == TIMEOUT) begin
        m_verdict = 1'b1;
        m_fail_id = 31'd0;
        m_pass    = 1'b0;
        m_timeout = 1'b1;
        model_build_message();
        check_verdict("timeout");
      end else begin
        check_output("no_early_done", 32'(done), 32'd0);
      end
    end
  endtask

  // Idle cycles with optional random retires and non-verdict CSR writes.
  task automatic idle_cycles(input int n, input bit noise);
    logic [11:0] a;
    logic [31:0] d;
    bit          w;
    bit          r;
    for (int i = 0; i < n; i++) begin
      w = 1'b0;
      a = 12'h000;
      d = 32'd0;
      r = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise && ($urandom_range(0, 7) == 0)) begin
        w = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          a = 12'($urandom);
          if (a == TOHOST) a = 12'h300;
          d = $urandom;
        end else begin
          a = TOHOST;
          d = $urandom & 32'hFFFF_FFFE;
        end
      end
      apply_stimulus(w, a, d, r);
    end
  endtask

  // Drains the verdict message. mode 0: random ready, 1: five stall cycles
  // before every byte, 2: always ready. Stops after max_bytes bytes.
  task automatic collect_message(input int mode, input int max_bytes);
    logic [7:0] got[$];
    logic [7:0] prev_data;
    bit         prev_stalled;
    bit         ready;
    int         stall_ctr;
    int         want;
    prev_stalled = 1'b0;
    prev_data    = 8'd0;
    stall_ctr    = 0;
    want         = (max_bytes < m_msg.size()) ? max_bytes : m_msg.size();
    for (int cyc = 0; (cyc < 300) && (got.size() < want); cyc++) begin
      check_output("tx_valid_held", 32'(tx_valid), 32'd1);
      if (prev_stalled) check_output("tx_data_stable", 32'(tx_data), 32'(prev_data));
      case (mode)
        1:       ready = (stall_ctr == 5);
        2:       ready = 1'b1;
        default: ready = 1'($urandom_range(0, 1));
      endcase
      tx_ready     = ready;
      prev_data    = tx_data;
      prev_stalled = tx_valid && !ready;
      csr_we       = 1'($urandom_range(0, 1));
      csr_addr     = TOHOST;
      csr_wdata    = $urandom | 32'd1;
      instr_retire = 1'($urandom_range(0, 1));
      tick();
      if (ready) begin
        got.push_back(prev_data);
        stall_ctr = 0;
      end else begin
        stall_ctr++;
      end
    end
    tx_ready     = 1'b0;
    csr_we       = 1'b0;
    instr_retire = 1'b0;
    check_output("byte_count", 32'(got.size()), 32'(want));
    for (int i = 0; (i < want) && (i < got.size()); i++) begin
      check_output($sformatf("byte%0d", i), 32'(got[i]), 32'(m_msg[i]));
    end
    if (want == m_msg.size()) begin
      check_output("tx_valid_after_msg", 32'(tx_valid), 32'd0);
      check_output("cycle_count_frozen", cycle_count, 32'(m_cycles));
      check_output("instret_frozen", instret, 32'(m_instret));
    end
  endtask

  // After the message: further hits, retires and ready do nothing.
  task automatic halt_check();
    for (int i = 0; i < 4; i++) begin
      csr_we       = 1'b1;
      csr_addr     = TOHOST;
      csr_wdata    = $urandom | 32'd1;
      instr_retire = 1'b1;
      tx_ready     = 1'b1;
      tick();
      check_output("halt_tx_valid", 32'(tx_valid), 32'd0);
      check_output("halt_done", 32'(done), 32'd1);
      check_output("halt_pass", 32'(pass), 32'(m_pass));
      check_output("halt_timed_out", 32'(timed_out), 32'(m_timeout));
      check_output("halt_fail_id", 32'(fail_id), 32'(m_fail_id));
      check_output("halt_cycle_count", cycle_count, 32'(m_cycles));
      check_output("halt_instret", instret, 32'(m_instret));
    end
    csr_we       = 1'b0;
    instr_retire = 1'b0;
    tx_ready     = 1'b0;
  endtask

  // Asynchronous reset mid-cycle, checks everything cleared, then releases it.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_pass", 32'(pass), 32'd0);
    check_output("rst_timed_out", 32'(timed_out), 32'd0);
    check_output("rst_fail_id", 32'(fail_id), 32'd0);
    check_output("rst_cycle_count", cycle_count, 32'd0);
    check_output("rst_instret", instret, 32'd0);
    check_output("rst_tx_data", 32'(tx_data), 32'd0);
    check_output("rst_tx_valid", 32'(tx_valid), 32'd0);
    tick();
    tick();
    rst       = 1'b1;
    m_cycles  = 0;
    m_instret = 0;
    m_verdict = 1'b0;
    m_pass    = 1'b0;
    m_timeout = 1'b0;
    m_fail_id = 31'd0;
    m_msg.delete();
  endtask

  initial begin
    logic [31:0] wd;
    int          delay;
    rst          = 1'b1;
    csr_we       = 1'b0;
    csr_addr     = 12'h000;
    csr_wdata    = 32'd0;
    instr_retire = 1'b0;
    tx_ready     = 1'b0;
    tick();

    $display("[TB] pass verdict on cycle 50");
    do_reset();
    idle_cycles(49, 1'b0);
    apply_stimulus(1'b1, TOHOST, 32'h1, 1'b0);
    check_output("t1_cycle_count_50", cycle_count, 32'd50);
    check_output("t1_pass", 32'(pass), 32'd1);
    collect_message(2, 16);
    halt_check();

    $display("[TB] fail verdict with id 3");
    do_reset();
    idle_cycles(10, 1'b1);
    apply_stimulus(1'b1, TOHOST, 32'h0000_0007, 1'b1);
    check_output("t2_fail_id_3", 32'(fail_id), 32'd3);
    collect_message(0, 16);

    $display("[TB] ignored writes then timeout");
    do_reset();
    apply_stimulus(1'b1, TOHOST, 32'h0000_0006, 1'b0);
    apply_stimulus(1'b1, 12'h300, 32'h1, 1'b0);
    idle_cycles(TIMEOUT - 2, 1'b0);
    check_output("t3_timed_out", 32'(timed_out), 32'd1);
    check_output("t3_cycle_count", cycle_count, 32'd2000);
    collect_message(0, 16);

    $display("[TB] hit on the timeout cycle");
    do_reset();
    idle_cycles(TIMEOUT - 1, 1'b0);
    check_output("t4_cycle_before", cycle_count, 32'd1999);
    apply_stimulus(1'b1, TOHOST, 32'h1, 1'b0);
    check_output("t4_pass", 32'(pass), 32'd1);
    check_output("t4_timed_out", 32'(timed_out), 32'd0);
    check_output("t4_cycle_count", cycle_count, 32'd2000);
    collect_message(2, 16);

    $display("[TB] stalled fail message");
    do_reset();
    idle_cycles(int'($urandom_range(1, 60)), 1'b1);
    wd = $urandom | 32'd1;
    if (wd[31:1] == 31'd0) wd = 32'h3;
    apply_stimulus(1'b1, TOHOST, wd, 1'b1);
    collect_message(1, 16);
    halt_check();

    $display("[TB] reset mid-message then fresh pass run");
    do_reset();
    idle_cycles(20, 1'b1);
    apply_stimulus(1'b1, TOHOST, 32'hDEAD_BEEF, 1'b0);
    collect_message(2, 3);
    do_reset();
    idle_cycles(30, 1'b0);
    apply_stimulus(1'b1, TOHOST, 32'h1, 1'b1);
    check_output("t6_cycle_count", cycle_count, 32'd31);
    collect_message(0, 16);
    halt_check();

    $display("[TB] randomized runs");
    for (int iter = 0; iter < 6; iter++) begin
      do_reset();
      delay = int'($urandom_range(1, 400));
      idle_cycles(delay, 1'b1);
      wd = ($urandom_range(0, 2) == 0) ? 32'h1 : ($urandom | 32'd1);
      apply_stimulus(1'b1, TOHOST, wd, 1'($urandom_range(0, 1)));
      collect_message(0, 16);
      halt_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
